fifosc_param: RTL

Parametrised single-clock FIFO, the successor to the fixed 8-deep FIFO. Depth, data width and almost-full/almost-empty thresholds are set at elaboration. It adds an occupancy count, threshold flags, overflow/underflow pulses and an asynchronous active-low reset, alongside the existing synchronous flush. It sits between a producer and a consumer in the same clock domain and keeps the registered-read, insert/remove/flush handshake of the current FIFO.

---
 rtl/fifosc_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifosc_param.sv
// Parametrised single-clock FIFO: registered dout one clock after remove, with occupancy count and threshold flags.
// No backpressure: an insert when full is dropped (overflow pulse); a remove when empty holds dout (underflow pulse).
module fifosc_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  insert,
  input  logic                  remove,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = AEMPTY_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wrptr_q, wrptr_d;
  logic [ADDR_WIDTH-1:0] rdptr_q, rdptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  empty_q, full_q, aempty_q, afull_q;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_en;

  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    wr_en   = 1'b0;
    if (flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      count_d = '0;
      dout_d  = '0;
    end else begin
      unique case ({remove, insert})
        2'b01: begin
          if (full_q) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wrptr_d = wrptr_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
          end
        end
        2'b10: begin
          if (empty_q) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = mem_q[rdptr_q];
            rdptr_d = rdptr_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
          end
        end
        2'b11: begin
          // On empty the word bypasses storage; otherwise read and write share the cycle, so a full FIFO never overflows here.
          if (empty_q) begin
            dout_d = din;
          end else begin
            dout_d  = mem_q[rdptr_q];
            wr_en   = 1'b1;
            wrptr_d = wrptr_q + PTR_ONE;
            rdptr_d = rdptr_q + PTR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrptr_q  <= '0;
      rdptr_q  <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= (AFULL_C == '0);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wrptr_q  <= wrptr_d;
      rdptr_q  <= rdptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
      aempty_q <= (count_d <= AEMPTY_C);
      afull_q  <= (count_d >= AFULL_C);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wrptr_q] <= din;
    end
  end

  assign dout         = dout_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
